// File: rtl/imem_prefetch_buffer.sv
// Instruction prefetch queue: pipelined sequential reads from a 1-cycle imem into a small FIFO with redirect flush.
// Optional performance counters are added when PREFETCH_PERF_CNT_EN is defined.
module imem_prefetch_buffer #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEMSIZE = 4096
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     stall,
   output logic [31:0]              imem_address,
   output logic                     imem_read_ready,
   input  logic [31:0]              imem_read_data,
   input  logic                     imem_is_valid,
   input  logic                     redirect_valid,
   input  logic [31:0]              redirect_pc,
   output logic                     inst_valid,
   output logic [31:0]              inst_data,
   output logic [31:0]              inst_pc,
   input  logic                     inst_ready,
   output logic                     exception,
   output logic [$clog2(DEPTH):0]   occupancy
`ifdef PREFETCH_PERF_CNT_EN
   ,
   output logic [31:0]              perf_flush_count,
   output logic [31:0]              perf_empty_count
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int AW = $clog2(IMEMSIZE);
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   function automatic logic addr_in_range(input logic [31:0] addr);
      return (addr >> AW) == 32'd0;
   endfunction

   logic [31:0]   fetch_pc_r;
   logic          epoch_r;
   logic          req_r;
   logic [31:0]   req_addr_r;
   logic          req_epoch_r;
   logic          rsp_pending_r;
   logic          rsp_epoch_r;
   logic [31:0]   rsp_pc_r;
   logic          exception_r;
   logic [31:0]   pc_mem_r   [DEPTH];
   logic [31:0]   data_mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          inst_valid_r;
   logic [31:0]   inst_pc_r;
   logic [31:0]   inst_data_r;

   logic          rsp_live_s;
   logic          push_s;
   logic          retry_s;
   logic          pop_s;
   logic [CW-1:0] count_next_s;
   logic [PW-1:0] rd_ptr_next_s;
   logic [PW-1:0] wr_ptr_next_s;
   logic [31:0]   base_pc_s;
   logic          misalign_s;
   logic          room_s;
   logic          want_s;
   logic          issue_s;
   logic          range_fault_s;
   logic          epoch_next_s;
   logic [31:0]   head_pc_next_s;
   logic [31:0]   head_data_next_s;

   assign imem_read_ready = req_r;
   assign imem_address    = req_addr_r;
   assign inst_valid      = inst_valid_r;
   assign inst_pc         = inst_pc_r;
   assign inst_data       = inst_data_r;
   assign exception       = exception_r;
   assign occupancy       = count_r;

   // Next-state decode: response accept/retry, FIFO accounting, next request decision and head lookahead.
   always_comb begin
      rsp_live_s    = rsp_pending_r && (rsp_epoch_r == epoch_r) && !redirect_valid;
      push_s        = rsp_live_s && imem_is_valid;
      retry_s       = rsp_live_s && !imem_is_valid;
      pop_s         = inst_valid_r && inst_ready && !redirect_valid;
      wr_ptr_next_s = wr_ptr_r + PW'(push_s);
      if (redirect_valid) begin
         count_next_s  = {CW{1'b0}};
         rd_ptr_next_s = wr_ptr_r;
      end else begin
         count_next_s  = count_r + CW'(push_s) - CW'(pop_s);
         rd_ptr_next_s = rd_ptr_r + PW'(pop_s);
      end
      // A failed response restarts at its own PC; the younger request already on the bus is killed by the epoch flip.
      if (redirect_valid) begin
         base_pc_s = redirect_pc;
      end else if (retry_s) begin
         base_pc_s = rsp_pc_r;
      end else begin
         base_pc_s = fetch_pc_r;
      end
      misalign_s    = redirect_valid && (redirect_pc[1:0] != 2'b00);
      // The request on the bus now still owes a response, so it reserves a slot alongside the new one.
      room_s        = ({1'b0, count_next_s} + {{CW{1'b0}}, req_r}) < DEPTH_W;
      want_s        = !stall && !exception_r && !misalign_s && room_s;
      issue_s       = want_s && addr_in_range(base_pc_s);
      range_fault_s = want_s && !addr_in_range(base_pc_s);
      epoch_next_s  = epoch_r ^ (redirect_valid || retry_s);
      if (count_next_s == {CW{1'b0}}) begin
         head_pc_next_s   = inst_pc_r;
         head_data_next_s = inst_data_r;
      end else if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
         head_pc_next_s   = rsp_pc_r;
         head_data_next_s = imem_read_data;
      end else begin
         head_pc_next_s   = pc_mem_r[rd_ptr_next_s];
         head_data_next_s = data_mem_r[rd_ptr_next_s];
      end
   end

   // Fetch, request pipeline, FIFO storage and registered head outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_r    <= RESET_PC;
         epoch_r       <= 1'b0;
         req_r         <= 1'b0;
         req_addr_r    <= RESET_PC;
         req_epoch_r   <= 1'b0;
         rsp_pending_r <= 1'b0;
         rsp_epoch_r   <= 1'b0;
         rsp_pc_r      <= 32'd0;
         exception_r   <= 1'b0;
         wr_ptr_r      <= {PW{1'b0}};
         rd_ptr_r      <= {PW{1'b0}};
         count_r       <= {CW{1'b0}};
         inst_valid_r  <= 1'b0;
         inst_pc_r     <= 32'd0;
         inst_data_r   <= 32'd0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_r[i]   <= 32'd0;
            data_mem_r[i] <= 32'd0;
         end
      end else begin
         fetch_pc_r    <= issue_s ? (base_pc_s + 32'd4) : base_pc_s;
         epoch_r       <= epoch_next_s;
         req_r         <= issue_s;
         req_addr_r    <= base_pc_s;
         req_epoch_r   <= epoch_next_s;
         rsp_pending_r <= req_r;
         rsp_epoch_r   <= req_epoch_r;
         rsp_pc_r      <= req_addr_r;
         exception_r   <= exception_r | misalign_s | range_fault_s;
         wr_ptr_r      <= wr_ptr_next_s;
         rd_ptr_r      <= rd_ptr_next_s;
         count_r       <= count_next_s;
         inst_valid_r  <= (count_next_s != {CW{1'b0}});
         inst_pc_r     <= head_pc_next_s;
         inst_data_r   <= head_data_next_s;
         if (push_s) begin
            pc_mem_r[wr_ptr_r]   <= rsp_pc_r;
            data_mem_r[wr_ptr_r] <= imem_read_data;
         end
      end
   end

`ifdef PREFETCH_PERF_CNT_EN
   logic [31:0] flush_cnt_r;
   logic [31:0] empty_cnt_r;

   assign perf_flush_count = flush_cnt_r;
   assign perf_empty_count = empty_cnt_r;

   // Flush and starvation event counters, wrapping at 2^32.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flush_cnt_r <= 32'd0;
         empty_cnt_r <= 32'd0;
      end else begin
         flush_cnt_r <= flush_cnt_r + {31'd0, redirect_valid};
         empty_cnt_r <= empty_cnt_r + {31'd0, (!inst_valid_r && !stall && !exception_r)};
      end
   end
`endif

endmodule

// File: doc/imem_prefetch_buffer.md
Name: imem_prefetch_buffer

Overview:
Instruction prefetch queue between the instruction memory and the fetch stage of the pipe core. It issues sequential word reads to the synchronous instruction memory, buffers returned words with their PCs in a small FIFO, and presents them to the fetch stage with a valid/ready handshake. Branch/jump redirects flush the queue and restart fetch at the new PC.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset
IMEMSIZE, 4096, instruction memory size in bytes; used for range check

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
stall  input  1  global stall; no new memory requests while high
imem_address  output  32  word-aligned read address to instruction memory
imem_read_ready  output  1  read request strobe this cycle
imem_read_data  input  32  read data, valid the cycle after a request
imem_is_valid  input  1  qualifies imem_read_data
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  32  new fetch PC
inst_valid  output  1  head entry available
inst_data  output  32  head instruction word
inst_pc  output  32  PC of head instruction
inst_ready  input  1  fetch stage accepts head when inst_valid
exception  output  1  sticky fault: misaligned redirect or address out of range
occupancy  output  $clog2(DEPTH)+1  current FIFO entry count

Behaviour:
- Reset (reset low, async): fetch_pc=RESET_PC, FIFO empty, occupancy=0, inst_valid=0, inst_data=0, inst_pc=0, imem_read_ready=0, imem_address=RESET_PC, exception=0, in-flight flag=0, epoch=0.
- Request rule: imem_read_ready=1 when !stall && !exception && !redirect_valid && (occupancy + inflight) < DEPTH. imem_address=fetch_pc; on request fetch_pc += 4 (32-bit wrap), inflight set with current epoch.
- Latency: memory returns data 1 cycle after request; if imem_is_valid=1 and response epoch == current epoch, push {pc, data}. If imem_is_valid=0, the request is reissued at the same PC (fetch_pc rolled back by 4, no push).
- Min latency request->inst_valid: 2 cycles (push registered). Back-to-back streaming sustains 1 instruction/cycle when inst_ready held high.
- Pop: inst_valid && inst_ready -> head advances. Push and pop in same cycle: occupancy unchanged; legal at full (pop frees slot) and at empty only after push registered (no bypass).
- Full: no request issued; in-flight accounting guarantees no overflow. Empty: inst_valid=0, inst_data/inst_pc hold last value.
- Redirect (priority over push/pop/request): FIFO cleared, occupancy=0, inst_valid=0 next cycle, fetch_pc=redirect_pc, epoch toggled so the in-flight response is discarded. First new request issues the cycle after redirect.
- redirect_pc[1:0]!=0 or any issued address with bits [31:$clog2(IMEMSIZE)]!=0 -> exception=1 (sticky until reset), all requests stop, FIFO drains normally.
- Reset asserted mid-operation: immediate return to reset values; in-flight response ignored.
- stall high: requests suppressed; in-flight response still accepted; pops still allowed.

Optional Feature:
PREFETCH_PERF_CNT_EN: when defined, adds outputs perf_flush_count[31:0] (increments per redirect_valid cycle) and perf_empty_count[31:0] (increments each cycle inst_valid=0 && !stall && !exception), both zero on reset, wrap at 2^32. When undefined, ports and counters are absent; all other behaviour identical.

Test Plan:
- Reset release, inst_ready=1, imem holding 0x00000013 at every word -> first request addr 0x0 one cycle after reset deassert; inst_valid with inst_pc=0x0 two cycles later; pcs 0x0,0x4,0x8,... one per cycle.
- inst_ready=0 for 10 cycles -> exactly DEPTH=4 requests issued, occupancy=4, imem_read_ready=0; then inst_ready=1 -> pcs 0x0..0xC pop in order, streaming resumes at 0x10.
- Redirect to 0x100 while occupancy=3 and one request in flight -> next cycle inst_valid=0, stale response dropped, first popped inst_pc=0x100.
- Redirect to 0x102 -> exception=1 sticky, no further imem_read_ready; reset low restores exception=0.
- Sequential fetch reaching 0x1000 (IMEMSIZE=4096) -> exception=1 on that request; entries 0xFF8, 0xFFC still delivered.
- imem_is_valid=0 for one response at 0x20 -> 0x20 reissued, delivered order 0x1C,0x20,0x24 with no gap or duplicate.
